// File: rtl/aes_arb_pkg.sv
// Shared types, widths and helpers for the AES request arbiter.
package aes_arb_pkg;

  localparam int unsigned KEY_W = 256;
  localparam int unsigned BLK_W = 128;

  localparam logic [1:0] AES_MODE_128 = 2'b00;
  localparam logic [1:0] AES_MODE_192 = 2'b01;
  localparam logic [1:0] AES_MODE_256 = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } arb_state_t;

  // Requester slot visited at offset ofs from base, wrapping modulo n (base < n, ofs < n).
  function automatic int unsigned rr_slot(input int unsigned base, input int unsigned ofs,
                                          input int unsigned n);
    int unsigned s;
    s = base + ofs;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Requester and core-side signal bundle of the AES request arbiter.
interface aes_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import aes_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_enc_dec;
  logic [NUM_REQ-1:0][1:0]       req_mode;
  logic [NUM_REQ-1:0][KEY_W-1:0] req_key;
  logic [NUM_REQ-1:0][BLK_W-1:0] req_data;

  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [BLK_W-1:0]              rsp_data;
  logic                          rsp_err;

  logic                          core_start;
  logic                          core_enc_dec;
  logic [1:0]                    core_mode;
  logic [KEY_W-1:0]              core_key;
  logic [BLK_W-1:0]              core_data_in;
  logic                          core_abort;
  logic [BLK_W-1:0]              core_data_out;
  logic                          core_done;

  // Arbiter side.
  modport slave (
    input  req_valid, req_enc_dec, req_mode, req_key, req_data, rsp_ready,
           core_data_out, core_done,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           core_start, core_enc_dec, core_mode, core_key, core_data_in, core_abort
  );

  // Requesters plus the core, seen from outside the arbiter.
  modport master (
    output req_valid, req_enc_dec, req_mode, req_key, req_data, rsp_ready,
           core_data_out, core_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           core_start, core_enc_dec, core_mode, core_key, core_data_in, core_abort
  );

endinterface

// File: rtl/aes_rr_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module aes_rr_picker
  import aes_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0] slot;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    slot  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot = IdxW'(rr_slot(32'(ptr), i, NUM_REQ));
      if (!any && req[slot]) begin
        any         = 1'b1;
        idx         = slot;
        grant[slot] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core between NUM_REQ requesters: round-robin accept, run, return result.
// Optional watchdog in BUSY enabled by defining AES_ARB_TIMEOUT_EN.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              reset_n,
  aes_req_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_t         state_q;
  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    owner_q;
  logic [IdxW-1:0]    owner_inc;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [BLK_W-1:0]   rsp_data_q;
  logic               core_start_q;
  logic               enc_dec_q;
  logic [1:0]         mode_q;
  logic [KEY_W-1:0]   key_q;
  logic [BLK_W-1:0]   blk_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;
  logic               timeout;

  aes_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign owner_inc = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);

  assign bus.req_ready    = (state_q == IDLE) ? pick_grant : '0;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.core_start   = core_start_q;
  assign bus.core_enc_dec = enc_dec_q;
  assign bus.core_mode    = mode_q;
  assign bus.core_key     = key_q;
  assign bus.core_data_in = blk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      core_start_q <= 1'b0;
      enc_dec_q    <= 1'b0;
      mode_q       <= '0;
      key_q        <= '0;
      blk_q        <= '0;
    end else begin
      core_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q      <= pick_idx;
            enc_dec_q    <= bus.req_enc_dec[pick_idx];
            mode_q       <= bus.req_mode[pick_idx];
            key_q        <= bus.req_key[pick_idx];
            blk_q        <= bus.req_data[pick_idx];
            core_start_q <= 1'b1;
            state_q      <= START;
          end
        end
        START: state_q <= BUSY;
        BUSY: begin
          // A done in the same cycle as the watchdog limit still wins.
          if (bus.core_done) begin
            rsp_data_q  <= bus.core_data_out;
            rsp_valid_q <= NUM_REQ'(1) << owner_q;
            state_q     <= RESP;
          end else if (timeout) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= NUM_REQ'(1) << owner_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= owner_inc;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  // Firing one cycle early lets the registered abort land TIMEOUT_CYCLES after core_start.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 2);

  logic [7:0] cnt_q;
  logic       rsp_err_q;
  logic       abort_q;

  assign timeout = (state_q == BUSY) && !bus.core_done && (cnt_q == TimeoutLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= timeout;
      if (state_q == START) begin
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if ((state_q == BUSY) && bus.core_done) begin
        rsp_err_q <= 1'b0;
      end else if (timeout) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign bus.rsp_err    = rsp_err_q;
  assign bus.core_abort = abort_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign bus.rsp_err        = 1'b0;
  assign bus.core_abort     = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomised bench for aes_req_arbiter with a transaction-level reference model and core stub.
module tb_aes_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  localparam int PIdle  = 0;
  localparam int PStart = 1;
  localparam int PBusy  = 2;
  localparam int PResp  = 3;

  localparam logic [255:0] KatKey = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] KatPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KatCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  aes_req_arbiter_if #(.NUM_REQ(N)) bus ();

  aes_req_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Requester-side drive values.
  logic [N-1:0] drv_valid, drv_enc, drv_rsp_ready;
  logic [1:0]   drv_mode [N];
  logic [255:0] drv_key  [N];
  logic [127:0] drv_data [N];

  // Reference model state.
  int           phase, ptr, owner, busy_left, cyc, start_cyc, abort_cyc, ops_done, abort_seen;
  int           lat_min, lat_max;
  bit           core_mute, one_shot, rand_req, done_now;
  logic [255:0] acc_key;
  logic [127:0] acc_data, exp_rsp, last_rsp;
  logic [1:0]   acc_mode;
  logic         acc_enc, exp_err, last_err;
  int           grants[$];

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // Stand-in for the AES core: known FIPS-197 vector, otherwise a cheap keyed mix.
  function automatic logic [127:0] core_fn(logic [255:0] k, logic [127:0] d, logic [1:0] m,
                                           logic e);
    if (k == KatKey && m == 2'b00 && !e && d == KatPt) return KatCt;
    if (k == KatKey && m == 2'b00 && e && d == KatCt) return KatPt;
    return {d[126:0], d[127]} ^ k[255:128] ^ k[127:0] ^ {124'd0, e, 1'b0, m};
  endfunction

  function automatic int rr_winner(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    int w;
    logic [N-1:0] exp_ready, exp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (rand_req) begin
      for (int k = 0; k < N; k++) begin
        drv_valid[k]     = ($urandom_range(0, 2) != 0);
        drv_enc[k]       = 1'($urandom);
        drv_mode[k]      = 2'($urandom);
        drv_key[k]       = rand256();
        drv_data[k]      = rand128();
        drv_rsp_ready[k] = 1'($urandom);
      end
    end
    for (int k = 0; k < N; k++) begin
      bus.req_valid[k]   = drv_valid[k];
      bus.req_enc_dec[k] = drv_enc[k];
      bus.req_mode[k]    = drv_mode[k];
      bus.req_key[k]     = drv_key[k];
      bus.req_data[k]    = drv_data[k];
    end
    bus.rsp_ready     = drv_rsp_ready;
    bus.core_done     = 1'b0;
    bus.core_data_out = '0;
    done_now          = 1'b0;
    if (phase == PBusy && !core_mute) begin
      if (busy_left == 0) begin
        bus.core_done     = 1'b1;
        bus.core_data_out = core_fn(bus.core_key, bus.core_data_in, bus.core_mode,
                                    bus.core_enc_dec);
        done_now          = 1'b1;
      end else begin
        busy_left--;
      end
    end else if ((phase == PIdle || phase == PStart) && $urandom_range(0, 7) == 0) begin
      // Stray completions outside BUSY must be ignored.
      bus.core_done     = 1'b1;
      bus.core_data_out = rand128();
    end

    @(negedge clk);
    w         = rr_winner(drv_valid, ptr);
    exp_ready = (phase == PIdle && w >= 0) ? N'(1) << w : '0;
    exp_valid = (phase == PResp) ? N'(1) << owner : '0;
    check_val("req_ready", bus.req_ready, exp_ready);
    check_val("req_ready_onehot", $onehot0(bus.req_ready), 1);
    check_val("core_start", bus.core_start, phase == PStart);
    check_val("rsp_valid", bus.rsp_valid, exp_valid);
    check_val("core_abort", bus.core_abort, phase == PResp && cyc == abort_cyc);
    if (bus.core_abort) abort_seen++;
    if (phase == PStart || phase == PBusy) begin
      check_val("core_key", bus.core_key, acc_key);
      check_val("core_data_in", bus.core_data_in, acc_data);
      check_val("core_mode", bus.core_mode, acc_mode);
      check_val("core_enc_dec", bus.core_enc_dec, acc_enc);
    end
    if (phase == PResp) begin
      check_val("rsp_data", bus.rsp_data, exp_rsp);
      check_val("rsp_err", bus.rsp_err, exp_err);
    end

    case (phase)
      PIdle: begin
        if (w >= 0) begin
          owner    = w;
          acc_key  = drv_key[w];
          acc_data = drv_data[w];
          acc_mode = drv_mode[w];
          acc_enc  = drv_enc[w];
          exp_rsp  = core_fn(acc_key, acc_data, acc_mode, acc_enc);
          exp_err  = 1'b0;
          grants.push_back(w);
          if (one_shot) drv_valid[w] = 1'b0;
          phase = PStart;
        end
      end
      PStart: begin
        start_cyc = cyc;
        busy_left = $urandom_range(lat_max, lat_min);
        phase     = PBusy;
      end
      PBusy: begin
        if (done_now) begin
          phase = PResp;
        end else if (core_mute && cyc + 1 == start_cyc + TO) begin
          exp_rsp   = '0;
          exp_err   = 1'b1;
          abort_cyc = cyc + 1;
          phase     = PResp;
        end
      end
      default: begin
        if (drv_rsp_ready[owner]) begin
          last_rsp = bus.rsp_data;
          last_err = bus.rsp_err;
          ptr      = (owner + 1) % N;
          ops_done++;
          phase    = PIdle;
        end
      end
    endcase
  endtask

  task automatic run_ops(input int n, input int budget);
    int target;
    target = ops_done + n;
    while (ops_done < target && budget > 0) begin
      step();
      budget--;
    end
    if (ops_done < target) check_val("op_budget", ops_done, target);
  endtask

  task automatic wait_phase(input int p, input int budget);
    while (phase != p && budget > 0) begin
      step();
      budget--;
    end
    check_val("phase_reached", phase, p);
  endtask

  task automatic do_reset();
    drv_valid     = '0;
    bus.req_valid = '0;
    bus.core_done = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check_val("rst_req_ready", bus.req_ready, 0);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_rsp_data", bus.rsp_data, 0);
    check_val("rst_rsp_err", bus.rsp_err, 0);
    check_val("rst_core_start", bus.core_start, 0);
    check_val("rst_core_enc_dec", bus.core_enc_dec, 0);
    check_val("rst_core_mode", bus.core_mode, 0);
    check_val("rst_core_key", bus.core_key, 0);
    check_val("rst_core_data_in", bus.core_data_in, 0);
    check_val("rst_core_abort", bus.core_abort, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    phase   = PIdle;
    ptr     = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [127:0] held;
    phase = PIdle; ptr = 0; owner = 0; busy_left = 0; cyc = 0; start_cyc = 0;
    abort_cyc = -1; ops_done = 0; abort_seen = 0; lat_min = 0; lat_max = 5;
    core_mute = 1'b0; one_shot = 1'b1; rand_req = 1'b0;
    drv_valid = '0; drv_enc = '0; drv_rsp_ready = '1;
    for (int k = 0; k < N; k++) begin
      drv_mode[k] = '0;
      drv_key[k]  = '0;
      drv_data[k] = '0;
    end
    bus.req_valid = '0; bus.req_enc_dec = '0; bus.req_mode = '0; bus.req_key = '0;
    bus.req_data = '0; bus.rsp_ready = '0; bus.core_done = 1'b0; bus.core_data_out = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Known-answer encrypt from requester 0, then decrypt from requester 1.
    drv_valid = 4'b0001; drv_key[0] = KatKey; drv_data[0] = KatPt; drv_mode[0] = 2'b00;
    drv_enc[0] = 1'b0;
    run_ops(1, 50);
    check_val("kat_enc", last_rsp, KatCt);
    check_val("kat_enc_err", last_err, 0);
    drv_valid = 4'b0010; drv_key[1] = KatKey; drv_data[1] = KatCt; drv_mode[1] = 2'b00;
    drv_enc[1] = 1'b1;
    run_ops(1, 50);
    check_val("kat_dec", last_rsp, KatPt);

    // Fairness from a fresh pointer with every requester always valid.
    do_reset();
    grants.delete();
    one_shot = 1'b0;
    for (int k = 0; k < N; k++) begin
      drv_key[k] = rand256(); drv_data[k] = rand128(); drv_mode[k] = 2'($urandom);
      drv_enc[k] = 1'($urandom);
    end
    drv_valid = '1;
    run_ops(6, 200);
    drv_valid = '0;
    one_shot  = 1'b1;
    check_val("fair_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check_val("fair_order", grants[i], i % N);

    // Backpressure: owner's rsp_ready low for 20 cycles, other bits and requests active.
    drv_valid = 4'b0100; drv_key[2] = rand256(); drv_data[2] = rand128();
    wait_phase(PResp, 50);
    drv_valid     = 4'b1011;
    drv_rsp_ready = ~(N'(1) << owner);
    step();
    held = bus.rsp_data;
    repeat (19) begin
      step();
      check_val("bp_rsp_data_stable", bus.rsp_data, held);
    end
    drv_rsp_ready = '1;
    run_ops(4, 200);

    // Reset in the middle of a long AES-256 operation, then verify recovery.
    lat_min = 30; lat_max = 40;
    drv_valid = 4'b1000; drv_mode[3] = 2'b10; drv_key[3] = rand256(); drv_data[3] = rand128();
    wait_phase(PBusy, 50);
    repeat (5) step();
    do_reset();
    lat_min = 0; lat_max = 5;
    grants.delete();
    drv_valid = 4'b1010; drv_mode[1] = 2'b10; drv_mode[3] = 2'b11;
    drv_key[1] = rand256(); drv_data[1] = rand128();
    drv_key[3] = rand256(); drv_data[3] = rand128();
    run_ops(2, 100);
    check_val("post_rst_first", grants.size() > 0 ? grants[0] : -1, 1);
    check_val("post_rst_second", grants.size() > 1 ? grants[1] : -1, 3);

    // Random traffic, then drain.
    rand_req = 1'b1;
    repeat (400) step();
    rand_req      = 1'b0;
    drv_valid     = '0;
    drv_rsp_ready = '1;
    wait_phase(PIdle, 60);

`ifdef AES_ARB_TIMEOUT_EN
    // Core never answers: expect one abort and an error response.
    core_mute  = 1'b1;
    abort_seen = 0;
    drv_valid  = 4'b0001; drv_key[0] = rand256(); drv_data[0] = rand128();
    run_ops(1, 2 * TO + 20);
    check_val("to_err", last_err, 1);
    check_val("to_data", last_rsp, 0);
    check_val("to_abort_count", abort_seen, 1);
    core_mute = 1'b0;
    drv_valid = 4'b0001;
    run_ops(1, 50);
    check_val("to_recover_err", last_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
